song_select_input: RTL and testbench
====================================

// Module: song_select_input
// PURPOSE
//  Front end for the user buttons. Produces the song number and mode that drive the
//  seven-segment display driver and the player, plus a play-start pulse.
//  Each button is synchronised, debounced and edge-detected, then fed to a selection
//  state machine: song up/down with wrap-around, mode cycling, and play confirm.
// PARAMETERS
//  DEBOUNCE_CYCLES  2_000_000  cycles a raw level must stay unchanged before it is accepted (20 ms @ 100 MHz)
//  NUM_SONGS        3          valid song numbers are 1..NUM_SONGS (max 9)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-low reset
//  btn_up       in   1  raw push button, active-high, asynchronous to clk
//  btn_down     in   1  raw push button, active-high
//  btn_mode     in   1  raw push button, active-high
//  btn_confirm  in   1  raw push button, active-high
//  play_busy    in   1  high while the player is playing a song
//  num          out  4  selected song, 1..NUM_SONGS
//  mode         out  3  one-hot mode: 3'b001 FREE, 3'b010 AUTO, 3'b100 LEARN
//  num_changed  out  1  one-cycle pulse when num updates
//  play_start   out  1  one-cycle pulse requesting playback of num
// BEHAVIOUR
//  Reset (reset==0, async): num=4'd1, mode=3'b001, num_changed=0, play_start=0;
//   all sync flops, debounce counters and stable levels are cleared to 0.
//  Per button: 2-FF synchroniser -> debounce -> rising-edge detect.
//   - The counter increments while the synced level != stable level, and clears when they are equal.
//   - When the count reaches DEBOUNCE_CYCLES-1, stable takes the synced level and the counter clears.
//   - press pulse = stable rising edge, exactly 1 cycle. A release produces no pulse.
//   - A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
//   - Holding a button gives one pulse only (no auto-repeat).
//   - Latency from a raw edge to the press pulse: 2 + DEBOUNCE_CYCLES + 1 cycles.
//  Selection logic, evaluated in the cycle after the press pulses; all outputs registered:
//   - up_p & !down_p & !play_busy: num = (num==NUM_SONGS) ? 1 : num+1, and num_changed=1.
//   - down_p & !up_p & !play_busy: num = (num==1) ? NUM_SONGS : num-1, and num_changed=1.
//   - up_p & down_p in the same cycle: both are ignored; num and num_changed are unchanged/0.
//   - mode_p & !play_busy: mode rotates 001->010->100->001. num is unchanged.
//   - mode_p together with up_p or down_p in the same cycle: both take effect.
//   - confirm_p & mode==3'b010 & !play_busy: play_start=1 for one cycle.
//     confirm_p in any other mode, or while busy, is dropped.
//   - Every press while play_busy==1 is discarded, not queued.
//  num never leaves 1..NUM_SONGS. Any out-of-range value is forced to 1 on the next cycle.
//  mode is always one-hot. Any non-one-hot value is forced to 3'b001 on the next cycle.
//  Reset asserted mid-debounce or mid-pulse: all pulses drop immediately, and a held
//   button after reset release needs a full debounce before its press counts.
// STRUCTURE
//  Shared package (display/player constants): MODE_FREE=3'b001, MODE_AUTO=3'b010,
//   MODE_LEARN=3'b100, SONG_STAR=1, SONG_BDAY=2, SONG_YEAR=3, NUM_W=4.
//  One sub-module, btn_debounce (params DEBOUNCE_CYCLES; ports clk, reset, raw, level, press),
//   instantiated four times. The selection FSM and output registers live in the top.
//  Debounce counter width is $clog2(DEBOUNCE_CYCLES)+1.
// TESTING (DEBOUNCE_CYCLES=4, NUM_SONGS=3)
//  1. Reset: hold reset=0 with all buttons high -> num=1, mode=001, pulses 0.
//     After release, btn_up held -> exactly one num_changed, num=2, 7 cycles after the edge.
//  2. Wrap: from num=3, press up -> num=1. Then press down -> num=3.
//     Each press gives exactly one num_changed pulse.
//  3. Bounce: btn_up toggles with 2-cycle high/low for 20 cycles, then stays high
//     -> exactly one increment, after the final stable period.
//  4. Simultaneous: btn_up and btn_down rise on the same cycle -> num unchanged, no num_changed.
//     btn_mode with btn_up on the same cycle -> mode advances and num increments.
//  5. Modes and play: press mode three times -> 010,100,001.
//     In 010, confirm -> one-cycle play_start. In 001, confirm -> none.
//  6. Busy lock: play_busy=1, then press up, mode, confirm -> no output changes or pulses.
//     Deassert play_busy -> the next up increments normally.

Source files
------------

// File: rtl/song_select_input_pkg.sv
// Shared display/player constants, button bundle and mode rotation helper.
// Combinational only; no latency or backpressure.
package song_select_input_pkg;

  localparam int NUM_W = 4;

  localparam logic [2:0] MODE_FREE  = 3'b001;
  localparam logic [2:0] MODE_AUTO  = 3'b010;
  localparam logic [2:0] MODE_LEARN = 3'b100;

  localparam logic [NUM_W-1:0] SONG_STAR = 4'd1;
  localparam logic [NUM_W-1:0] SONG_BDAY = 4'd2;
  localparam logic [NUM_W-1:0] SONG_YEAR = 4'd3;

  typedef enum logic [2:0] {
    ST_FREE  = MODE_FREE,
    ST_AUTO  = MODE_AUTO,
    ST_LEARN = MODE_LEARN
  } mode_e;

  typedef struct packed {
    logic confirm;
    logic mode;
    logic down;
    logic up;
  } btn_t;

  function automatic mode_e mode_rotate(input mode_e m);
    case (m)
      ST_FREE:  return ST_AUTO;
      ST_AUTO:  return ST_LEARN;
      default:  return ST_FREE;
    endcase
  endfunction

endpackage

// File: rtl/song_select_input_btn_debounce.sv
// One button: 2-FF synchroniser, debounce, rising-edge press pulse.
// Press is valid 2+DEBOUNCE_CYCLES+1 edges after the raw edge; no backpressure.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync0;
  logic             sync1;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0    <= 1'b0;
      sync1    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync0    <= raw;
      sync1    <= sync0;
      stable_d <= stable;
      // Any sample matching the accepted level restarts the qualification window.
      if (sync1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = stable;
  assign press = stable & ~stable_d;

endmodule

// File: rtl/song_select_input.sv
// Button front end: debounced presses drive song number, one-hot mode and play request.
// Outputs registered one edge after the press pulse; presses while play_busy are dropped.
import song_select_input_pkg::*;

module song_select_input #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int NUM_SONGS       = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_mode,
  input  logic             btn_confirm,
  input  logic             play_busy,
  output logic [NUM_W-1:0] num,
  output logic [2:0]       mode,
  output logic             num_changed,
  output logic             play_start
);

  localparam logic [NUM_W-1:0] LAST_SONG = NUM_W'(NUM_SONGS);

  btn_t btn_press;
  btn_t btn_level;
  logic unused_levels;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_up),
    .level (btn_level.up),
    .press (btn_press.up)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_down),
    .level (btn_level.down),
    .press (btn_press.down)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_mode),
    .level (btn_level.mode),
    .press (btn_press.mode)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_confirm (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_confirm),
    .level (btn_level.confirm),
    .press (btn_press.confirm)
  );

  // Held levels are not needed by the selection logic.
  assign unused_levels = ^btn_level;

  mode_e            mode_q;
  mode_e            mode_nxt;
  logic [NUM_W-1:0] num_q;
  logic [NUM_W-1:0] num_nxt;
  logic             num_changed_nxt;
  logic             play_start_nxt;
  logic             num_ok;
  logic             accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q      <= ST_FREE;
      num_q       <= SONG_STAR;
      num_changed <= 1'b0;
      play_start  <= 1'b0;
    end else begin
      mode_q      <= mode_nxt;
      num_q       <= num_nxt;
      num_changed <= num_changed_nxt;
      play_start  <= play_start_nxt;
    end
  end

  always_comb begin
    num_nxt         = num_q;
    mode_nxt        = mode_q;
    num_changed_nxt = 1'b0;
    play_start_nxt  = 1'b0;
    accept          = ~play_busy;
    num_ok          = (num_q != '0) && (num_q <= LAST_SONG);

    // Song select: opposing presses in the same cycle cancel out.
    if (!num_ok) begin
      num_nxt = SONG_STAR;
    end else if (accept && btn_press.up && !btn_press.down) begin
      num_nxt         = (num_q == LAST_SONG) ? SONG_STAR : num_q + 1'b1;
      num_changed_nxt = 1'b1;
    end else if (accept && btn_press.down && !btn_press.up) begin
      num_nxt         = (num_q == SONG_STAR) ? LAST_SONG : num_q - 1'b1;
      num_changed_nxt = 1'b1;
    end

    case (mode_q)
      ST_FREE, ST_AUTO, ST_LEARN: begin
        if (accept && btn_press.mode) begin
          mode_nxt = mode_rotate(mode_q);
        end
        // Confirm is judged against the mode in force before any rotation.
        if (accept && btn_press.confirm && (mode_q == ST_AUTO)) begin
          play_start_nxt = 1'b1;
        end
      end
      default: mode_nxt = ST_FREE;
    endcase
  end

  assign num  = num_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_song_select_input.sv
// Directed and random checks of song_select_input against a window-based button model.
module tb_song_select_input;

  localparam int D = 4;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btns = 4'b0000;   // [0] up, [1] down, [2] mode, [3] confirm
  logic       play_busy = 1'b0;
  logic [3:0] num;
  logic [2:0] mode;
  logic       num_changed;
  logic       play_start;

  int tests = 0;
  int fails = 0;
  int nc_cnt = 0;
  int ps_cnt = 0;

  // Reference model state
  int hist[4][$];
  bit m_stable[4];
  bit m_pend[4];
  int m_num;
  int m_midx;
  bit m_nc;
  bit m_ps;

  song_select_input #(.DEBOUNCE_CYCLES(D), .NUM_SONGS(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_up      (btns[0]),
    .btn_down    (btns[1]),
    .btn_mode    (btns[2]),
    .btn_confirm (btns[3]),
    .play_busy   (play_busy),
    .num         (num),
    .mode        (mode),
    .num_changed (num_changed),
    .play_start  (play_start)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      hist[b].delete();
      repeat (D + 2) hist[b].push_back(0);
      m_stable[b] = 1'b0;
      m_pend[b]   = 1'b0;
    end
    m_num  = 1;
    m_midx = 0;
    m_nc   = 1'b0;
    m_ps   = 1'b0;
  endtask

  // A level is accepted once D consecutive synchronised samples (raw delayed by two
  // edges) all differ from the accepted level; the press acts one edge later.
  task automatic model_edge();
    bit all_diff;
    int n;
    m_nc = 1'b0;
    m_ps = 1'b0;
    if (!play_busy) begin
      if (m_pend[0] && !m_pend[1]) begin
        m_num = m_num % N + 1;
        m_nc  = 1'b1;
      end else if (m_pend[1] && !m_pend[0]) begin
        m_num = (m_num + N - 2) % N + 1;
        m_nc  = 1'b1;
      end
      if (m_pend[3] && m_midx == 1) m_ps = 1'b1;
      if (m_pend[2]) m_midx = (m_midx + 1) % 3;
    end
    for (int b = 0; b < 4; b++) begin
      hist[b].push_back(int'(btns[b]));
      n = hist[b].size();
      all_diff = 1'b1;
      for (int k = 2; k <= D + 1; k++)
        if (hist[b][n-1-k] == int'(m_stable[b])) all_diff = 1'b0;
      m_pend[b] = 1'b0;
      if (all_diff) begin
        m_pend[b]   = !m_stable[b];
        m_stable[b] = !m_stable[b];
      end
      if (n > D + 4) void'(hist[b].pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge();
    #1;
    nc_cnt += int'(num_changed);
    ps_cnt += int'(play_start);
    tests++;
    assert (num === 4'(m_num)) else begin
      fails++; $error("FAIL num got=%0d exp=%0d", num, m_num);
    end
    tests++;
    assert (mode === 3'(1 << m_midx)) else begin
      fails++; $error("FAIL mode got=%b exp=%b", mode, 3'(1 << m_midx));
    end
    tests++;
    assert (num_changed === m_nc) else begin
      fails++; $error("FAIL num_changed got=%b exp=%b", num_changed, m_nc);
    end
    tests++;
    assert (play_start === m_ps) else begin
      fails++; $error("FAIL play_start got=%b exp=%b", play_start, m_ps);
    end
  endtask

  task automatic expect_val(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic press_btn(input logic [3:0] mask, input int hold);
    btns = mask;
    repeat (hold) tick();
    btns = 4'b0000;
    repeat (D + 4) tick();
  endtask

  initial begin
    model_reset();

    // 1. Reset with all buttons held, then up held across release
    btns = 4'b1111;
    repeat (3) tick();
    expect_val("rst_num", int'(num), 1);
    expect_val("rst_mode", int'(mode), 1);
    expect_val("rst_pulses", int'({num_changed, play_start}), 0);
    btns = 4'b0001;
    reset = 1'b1;
    nc_cnt = 0;
    repeat (6) tick();
    expect_val("lat_before", int'(num), 1);
    tick();
    expect_val("lat_num", int'(num), 2);
    expect_val("lat_nc", int'(num_changed), 1);
    repeat (10) tick();
    expect_val("hold_once", nc_cnt, 1);
    btns = 4'b0000;
    repeat (D + 4) tick();

    // 2. Wrap-around both directions
    press_btn(4'b0001, D + 4);
    expect_val("to3", int'(num), 3);
    nc_cnt = 0;
    press_btn(4'b0001, D + 4);
    expect_val("wrap_up", int'(num), 1);
    expect_val("wrap_up_nc", nc_cnt, 1);
    nc_cnt = 0;
    press_btn(4'b0010, D + 4);
    expect_val("wrap_dn", int'(num), 3);
    expect_val("wrap_dn_nc", nc_cnt, 1);

    // 3. Bounce then stable high
    nc_cnt = 0;
    repeat (5) begin
      btns = 4'b0001; tick(); tick();
      btns = 4'b0000; tick(); tick();
    end
    expect_val("bounce_none", nc_cnt, 0);
    press_btn(4'b0001, D + 8);
    expect_val("bounce_num", int'(num), 1);
    expect_val("bounce_nc", nc_cnt, 1);

    // 4. Simultaneous presses
    nc_cnt = 0;
    press_btn(4'b0011, D + 4);
    expect_val("updn_num", int'(num), 1);
    expect_val("updn_nc", nc_cnt, 0);
    press_btn(4'b0101, D + 4);
    expect_val("upmode_mode", int'(mode), 2);
    expect_val("upmode_num", int'(num), 2);

    // Reset mid-debounce with up still held: full debounce needed afterwards
    btns = 4'b0001;
    repeat (3) tick();
    reset = 1'b0;
    tick(); tick();
    expect_val("mid_rst_mode", int'(mode), 1);
    reset = 1'b1;
    repeat (6) tick();
    expect_val("mid_rst_wait", int'(num), 1);
    tick();
    expect_val("mid_rst_num", int'(num), 2);
    btns = 4'b0000;
    repeat (D + 4) tick();

    // 5. Mode cycling and play confirm
    press_btn(4'b0100, D + 4);
    expect_val("mode1", int'(mode), 2);
    press_btn(4'b0100, D + 4);
    expect_val("mode2", int'(mode), 4);
    press_btn(4'b0100, D + 4);
    expect_val("mode3", int'(mode), 1);
    ps_cnt = 0;
    press_btn(4'b1000, D + 4);
    expect_val("free_confirm", ps_cnt, 0);
    press_btn(4'b0100, D + 4);
    ps_cnt = 0;
    press_btn(4'b1000, D + 4);
    expect_val("auto_confirm", ps_cnt, 1);

    // 6. Busy lock
    play_busy = 1'b1;
    nc_cnt = 0;
    ps_cnt = 0;
    press_btn(4'b0001, D + 4);
    press_btn(4'b0100, D + 4);
    press_btn(4'b1000, D + 4);
    expect_val("busy_num", int'(num), 2);
    expect_val("busy_mode", int'(mode), 2);
    expect_val("busy_pulses", nc_cnt + ps_cnt, 0);
    play_busy = 1'b0;
    press_btn(4'b0001, D + 4);
    expect_val("unbusy_num", int'(num), 3);
    expect_val("unbusy_nc", nc_cnt, 1);

    // Random buttons, busy and occasional resets against the model
    repeat (300) begin
      btns = 4'($urandom_range(0, 15));
      play_busy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 40) == 0) begin
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
      end
      repeat ($urandom_range(1, 10)) tick();
    end
    btns = 4'b0000;
    play_busy = 1'b0;
    repeat (D + 4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
